// File: rtl/game_round_controller.sv
// Session controller above the game master: start gate, round judging, score/lives/level, game-over hold.
// All outputs registered; a round_start is judged one cycle later and its results are visible two cycles after the pulse.
module game_round_controller #(
  parameter int N_LIVES        = 3,
  parameter int HITS_PER_LEVEL = 4,
  parameter int N_LEVELS       = 4,
  parameter int SCORE_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key,
  input  logic                   round_start,
  input  logic                   round_won,
  input  logic                   timer_running,
  output logic                   master_hold,
  output logic [1:0]             level,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [1:0]             lives,
  output logic                   game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PLAY,
    S_JUDGE,
    S_SETTLE,
    S_OVER
  } state_t;

  localparam logic [1:0]             LIVES_INIT = 2'(N_LIVES);
  localparam logic [3:0]             HIT_LAST   = 4'(HITS_PER_LEVEL - 1);
  localparam logic [1:0]             LEVEL_MAX  = 2'(N_LEVELS - 1);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = '1;

  state_t                 state, state_nxt;
  logic                   key_d, key_rise;
  logic [3:0]             hit_cnt, hit_nxt;
  logic [1:0]             level_nxt, lives_nxt;
  logic [SCORE_WIDTH-1:0] score_nxt;
  logic                   hold_nxt, over_nxt;

  assign key_rise = key & ~key_d;

  always_comb begin
    state_nxt = state;
    hit_nxt   = hit_cnt;
    level_nxt = level;
    lives_nxt = lives;
    score_nxt = score;
    case (state)
      S_IDLE:  if (key_rise) state_nxt = S_ARM;
      // Wait for the start press to be released so the master never sees it as a fire.
      S_ARM:   if (!key) state_nxt = S_PLAY;
      S_PLAY:  if (round_start) state_nxt = S_JUDGE;
      S_JUDGE: begin
        state_nxt = S_SETTLE;
        if (round_won) begin
          if (score != SCORE_MAX) score_nxt = score + SCORE_WIDTH'(1);
          if (hit_cnt == HIT_LAST) begin
            hit_nxt = 4'd0;
            if (level < LEVEL_MAX) level_nxt = level + 2'd1;
          end else begin
            hit_nxt = hit_cnt + 4'd1;
          end
        end else if (lives != 2'd0) begin
          lives_nxt = lives - 2'd1;
        end
      end
      S_SETTLE: if (!timer_running) state_nxt = (lives == 2'd0) ? S_OVER : S_PLAY;
      S_OVER: begin
        if (key_rise) begin
          state_nxt = S_ARM;
          score_nxt = '0;
          lives_nxt = LIVES_INIT;
          level_nxt = 2'd0;
          hit_nxt   = 4'd0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state register.
    hold_nxt = (state_nxt == S_IDLE) || (state_nxt == S_ARM) || (state_nxt == S_OVER);
    over_nxt = (state_nxt == S_OVER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      key_d       <= 1'b0;
      hit_cnt     <= 4'd0;
      level       <= 2'd0;
      lives       <= LIVES_INIT;
      score       <= '0;
      master_hold <= 1'b1;
      game_over   <= 1'b0;
    end else begin
      state       <= state_nxt;
      key_d       <= key;
      hit_cnt     <= hit_nxt;
      level       <= level_nxt;
      lives       <= lives_nxt;
      score       <= score_nxt;
      master_hold <= hold_nxt;
      game_over   <= over_nxt;
    end
  end

endmodule

// File: tb/tb_game_round_controller.sv
// Scoreboard bench: stimulus queues expected output snapshots, a negedge monitor pops and compares.
// A second instance with SCORE_WIDTH=2 shares all inputs to exercise score saturation.
module tb_game_round_controller;

  logic       clk, reset, key, round_start, round_won, timer_running;
  logic       master_hold, game_over, master_hold2, game_over2;
  logic [1:0] level, lives, level2, lives2, score2;
  logic [7:0] score;

  typedef struct {
    string      name;
    logic       hold;
    logic [1:0] lvl;
    logic [7:0] sc;
    logic [1:0] lf;
    logic       go;
    logic [1:0] sc2;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  game_round_controller #(.SCORE_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .key(key), .round_start(round_start),
    .round_won(round_won), .timer_running(timer_running),
    .master_hold(master_hold), .level(level), .score(score),
    .lives(lives), .game_over(game_over)
  );

  game_round_controller #(.SCORE_WIDTH(2)) dut_small (
    .clk(clk), .reset(reset), .key(key), .round_start(round_start),
    .round_won(round_won), .timer_running(timer_running),
    .master_hold(master_hold2), .level(level2), .score(score2),
    .lives(lives2), .game_over(game_over2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (master_hold !== e.hold || level !== e.lvl || score !== e.sc || lives !== e.lf ||
          game_over !== e.go || score2 !== e.sc2 || level2 !== e.lvl) begin
        n_fail++;
        $display("FAIL %s: got hold=%0d level=%0d score=%0d lives=%0d over=%0d score2=%0d level2=%0d; want hold=%0d level=%0d score=%0d lives=%0d over=%0d score2=%0d",
                 e.name, master_hold, level, score, lives, game_over, score2, level2,
                 e.hold, e.lvl, e.sc, e.lf, e.go, e.sc2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic h, input logic [1:0] lv,
                            input logic [7:0] sc, input logic [1:0] lf, input logic go,
                            input logic [1:0] sc2);
    exp_t e;
    e.name = nm; e.hold = h; e.lvl = lv; e.sc = sc; e.lf = lf; e.go = go; e.sc2 = sc2;
    exp_q.push_back(e);
  endtask

  // Previous-round results, so mid-round checks know what must still be held.
  logic [1:0] p_lv = 2'd0;
  logic [7:0] p_sc = 8'd0;
  logic [1:0] p_lf = 2'd3;
  logic [1:0] p_sc2 = 2'd0;

  task automatic do_round(input string nm, input logic won, input int timer_n,
                          input logic [7:0] sc, input logic [1:0] sc2,
                          input logic [1:0] lv, input logic [1:0] lf, input logic over);
    round_start = 1'b1; round_won = won; timer_running = 1'b1;
    tick();
    round_start = 1'b0;
    expect_out({nm, "_judge"}, 1'b0, p_lv, p_sc, p_lf, 1'b0, p_sc2);
    tick();
    round_won = 1'b0;
    expect_out({nm, "_settle"}, 1'b0, lv, sc, lf, 1'b0, sc2);
    repeat (timer_n) tick();
    timer_running = 1'b0;
    tick();
    expect_out({nm, "_end"}, over, lv, sc, lf, over, sc2);
    p_lv = lv; p_sc = sc; p_lf = lf; p_sc2 = sc2;
  endtask

  initial begin
    reset = 1'b1; key = 1'b0; round_start = 1'b0; round_won = 1'b0; timer_running = 1'b0;
    tick(); tick();
    expect_out("in_reset", 1'b1, 2'd0, 8'd0, 2'd3, 1'b0, 2'd0);
    reset = 1'b0;
    repeat (10) tick();
    expect_out("idle", 1'b1, 2'd0, 8'd0, 2'd3, 1'b0, 2'd0);

    key = 1'b1;
    repeat (5) tick();
    expect_out("arm_key_held", 1'b1, 2'd0, 8'd0, 2'd3, 1'b0, 2'd0);
    key = 1'b0;
    expect_out("arm_release", 1'b1, 2'd0, 8'd0, 2'd3, 1'b0, 2'd0);
    tick();
    expect_out("play_hold_low", 1'b0, 2'd0, 8'd0, 2'd3, 1'b0, 2'd0);

    do_round("win1", 1'b1, 18, 8'd1, 2'd1, 2'd0, 2'd3, 1'b0);
    do_round("win2", 1'b1, 18, 8'd2, 2'd2, 2'd0, 2'd3, 1'b0);
    do_round("win3", 1'b1, 18, 8'd3, 2'd3, 2'd0, 2'd3, 1'b0);
    do_round("win4", 1'b1, 18, 8'd4, 2'd3, 2'd1, 2'd3, 1'b0);
    do_round("win5", 1'b1, 3, 8'd5, 2'd3, 2'd1, 2'd3, 1'b0);
    // A key press mid-game must be ignored.
    key = 1'b1; tick(); key = 1'b0; tick();
    expect_out("key_in_play", 1'b0, 2'd1, 8'd5, 2'd3, 1'b0, 2'd3);
    for (int i = 6; i <= 16; i++) begin
      logic [1:0] lv;
      lv = (i >= 12) ? 2'd3 : ((i >= 8) ? 2'd2 : 2'd1);
      do_round($sformatf("win%0d", i), 1'b1, 3, 8'(i), 2'd3, lv, 2'd3, 1'b0);
    end
    expect_out("after16", 1'b0, 2'd3, 8'd16, 2'd3, 1'b0, 2'd3);

    do_round("lose1", 1'b0, 5, 8'd16, 2'd3, 2'd3, 2'd2, 1'b0);
    do_round("lose2", 1'b0, 5, 8'd16, 2'd3, 2'd3, 2'd1, 1'b0);
    do_round("lose3", 1'b0, 5, 8'd16, 2'd3, 2'd3, 2'd0, 1'b1);

    round_start = 1'b1; round_won = 1'b0; timer_running = 1'b1;
    tick(); round_start = 1'b0; tick(); timer_running = 1'b0; tick(); tick();
    expect_out("over_ignores_round", 1'b1, 2'd3, 8'd16, 2'd0, 1'b1, 2'd3);

    key = 1'b1;
    tick();
    expect_out("restart_init", 1'b1, 2'd0, 8'd0, 2'd3, 1'b0, 2'd0);
    repeat (7) tick();
    expect_out("restart_key_held", 1'b1, 2'd0, 8'd0, 2'd3, 1'b0, 2'd0);
    key = 1'b0;
    tick();
    expect_out("restart_play", 1'b0, 2'd0, 8'd0, 2'd3, 1'b0, 2'd0);

    round_start = 1'b1; round_won = 1'b1; timer_running = 1'b1;
    tick(); round_start = 1'b0; tick(); round_won = 1'b0;
    expect_out("pre_reset_settle", 1'b0, 2'd0, 8'd1, 2'd3, 1'b0, 2'd1);
    tick();
    reset = 1'b1;
    expect_out("async_reset", 1'b1, 2'd0, 8'd0, 2'd3, 1'b0, 2'd0);
    tick();
    reset = 1'b0; timer_running = 1'b0;
    round_won = 1'b1; tick(); round_won = 1'b0;
    round_start = 1'b1; tick(); round_start = 1'b0;
    tick(); tick();
    expect_out("idle_after_reset", 1'b1, 2'd0, 8'd0, 2'd3, 1'b0, 2'd0);

    tick(); tick();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
